mod_inv256: RTL and testbench

MOD_INV256 -- requirements
Module: mod_inv256

---
 rtl/mod_inv256.sv | 221 ++++++++++++++++++++++
 tb/tb_mod_inv256.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_inv256.sv
// mod_inv256: modular inverse a^-1 mod modz by the binary extended
// Euclidean algorithm, one step per clock.
//
// Parameters:
//   modz       odd prime modulus (default: secp256k1 group order)
//   MAX_CYCLES worst-case update-to-done latency in clocks
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   update  start pulse; datax captured when update=1 and busy=0
//   datax   operand a, any 256-bit value
//   result  a^-1 mod modz, held until the next done
//   done    one-cycle pulse marking result/err valid
//   busy    high from the cycle after acceptance through the done cycle
//   err     set with done when a mod modz == 0, held until the next done
//
// Optional feature: define INV_CONST_TIME_EN to pad every operation so that
// done lands exactly MAX_CYCLES clocks after the accepted update.
module mod_inv256 #(
  parameter logic [255:0] modz =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141,
  parameter int unsigned  MAX_CYCLES = 1040
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         update,
  input  logic [255:0] datax,
  output logic [255:0] result,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int unsigned W = 256;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RED  = 3'd1,
    LOOP = 3'd2,
    PAD  = 3'd3,
    FIN  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   u_q, u_d;
  logic [W-1:0]   v_q, v_d;
  logic [W-1:0]   x1_q, x1_d;
  logic [W-1:0]   x2_q, x2_d;
  logic [W-1:0]   result_q, result_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           exit_c;
  logic           fin_c;
  logic [W-1:0]   u_fin;

`ifdef INV_CONST_TIME_EN
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CYC_MAX  = CW'(MAX_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(MAX_CYCLES - 1);
  // cyc_q equals k during the k-th clock after acceptance
  logic [CW-1:0]  cyc_q, cyc_d;
`endif

  // (x / 2) mod modz; odd x gets modz added first on a 257-bit sum
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, modz}) : {1'b0, x};
    return W'(s >> 1);
  endfunction

  // (x - y) mod modz for x, y already in 0..modz-1
  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    return (x >= y) ? (x - y) : (x - y + modz);
  endfunction

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    exit_c   = 1'b0;
    fin_c    = 1'b0;
    u_fin    = u_q;
`ifdef INV_CONST_TIME_EN
    cyc_d = cyc_q;
    if ((state_q != IDLE) && (cyc_q != CYC_MAX)) begin
      cyc_d = cyc_q + CW'(1);
    end
`endif

    case (state_q)
      IDLE: begin
        if (update && !busy_q) begin
          state_d = RED;
          u_d     = datax;
          v_d     = '0;
          x1_d    = '0;
          x2_d    = '0;
`ifdef INV_CONST_TIME_EN
          cyc_d   = CW'(1);
`endif
        end
      end

      RED: begin
        // datax < 2^256 < 2*modz, so one conditional subtract reduces fully
        u_d   = (u_q >= modz) ? (u_q - modz) : u_q;
        v_d   = modz;
        x1_d  = W'(1);
        x2_d  = '0;
        u_fin = u_d;
        if (u_d == '0) begin
          exit_c = 1'b1;
        end else begin
          state_d = LOOP;
        end
      end

      // Invariants: x1*a == u and x2*a == v (mod modz)
      LOOP: begin
        if ((u_q == W'(1)) || (v_q == W'(1))) begin
          exit_c = 1'b1;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = half_mod(x1_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = half_mod(x2_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub_mod(x1_q, x2_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub_mod(x2_q, x1_q);
        end
      end

      PAD: begin
        // operands frozen while waiting out the fixed latency
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef INV_CONST_TIME_EN
    fin_c = (exit_c || (state_q == PAD)) && (cyc_q >= CYC_LAST);
    if (exit_c && !fin_c) begin
      state_d = PAD;
    end
`else
    fin_c = exit_c;
`endif

    // u == 0 only survives to this point when the operand had no inverse
    if (fin_c) begin
      state_d  = FIN;
      done_d   = 1'b1;
      err_d    = (u_fin == '0);
      if (u_fin == '0) begin
        result_d = '0;
      end else if (u_fin == W'(1)) begin
        result_d = x1_q;
      end else begin
        result_d = x2_q;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef INV_CONST_TIME_EN
      cyc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      v_q      <= v_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
`ifdef INV_CONST_TIME_EN
      cyc_q    <= cyc_d;
`endif
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mod_inv256.sv
// Self-checking bench for mod_inv256: Fermat-exponentiation reference model,
// an expectation queue and a per-cycle monitor on the falling edge.
module tb_mod_inv256;

  localparam logic [255:0] N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [255:0] INV2 =
    256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_5D576E73_57A4501D_DFE92F46_681B20A1;
  localparam int unsigned MAXC = 1040;

  logic         clk = 1'b0;
  logic         rst;
  logic         update;
  logic [255:0] datax;
  logic [255:0] result;
  logic         done;
  logic         busy;
  logic         err;

  mod_inv256 #(.modz(N), .MAX_CYCLES(MAXC)) dut (
    .clk    (clk),
    .rst    (rst),
    .update (update),
    .datax  (datax),
    .result (result),
    .done   (done),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] a;
    logic [255:0] res;
    logic         err;
    int unsigned  drv_cyc;
    int unsigned  lat;
  } exp_t;

  exp_t        q[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned exp_done = 0;
  bit          in_flight = 1'b0;
  bit          prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] a,
                                          input logic [255:0] b);
    logic [511:0] p;
    p = {256'b0, a} * {256'b0, b};
    p = p % {256'b0, N};
    return p[255:0];
  endfunction

  // a^(N-2) mod N; yields 0 when a is a multiple of N
  function automatic logic [255:0] inv_model(input logic [255:0] a);
    logic [255:0] r;
    logic [255:0] base;
    logic [255:0] e;
    r    = 256'd1;
    base = a % N;
    e    = N - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulmod(r, base);
      base = mulmod(base, base);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Compare process: busy every cycle, result/err/latency on each done
  always @(negedge clk) begin
    exp_t        e;
    int unsigned lat;
    if (!rst) begin
      chk("busy", 256'(busy), 256'(in_flight));
      if (done && prev_done) chk("done_width", 256'(done), 256'd0);
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 256'(done), 256'd0);
        end else begin
          e   = q.pop_front();
          lat = cyc - e.drv_cyc;
          chk("result", result, e.res);
          chk("err", 256'(err), 256'(e.err));
          if (!e.err) chk("a_times_r", mulmod(result, e.a), 256'd1);
`ifdef INV_CONST_TIME_EN
          chk("latency", 256'(lat), 256'(MAXC));
`else
          if (e.lat != 0) chk("latency", 256'(lat), 256'(e.lat));
          else chk("latency_bound", 256'(lat <= MAXC), 256'd1);
`endif
        end
        in_flight = 1'b0;
        done_cnt++;
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic push_exp(input logic [255:0] a, input int unsigned lat,
                          input int unsigned drv);
    exp_t e;
    e.a       = a;
    e.res     = inv_model(a);
    e.err     = ((a % N) == 256'd0);
    e.drv_cyc = drv;
    e.lat     = lat;
    q.push_back(e);
    exp_done++;
  endtask

  task automatic start_op(input logic [255:0] a, input int unsigned lat);
    @(negedge clk);
    #1;
    push_exp(a, lat, cyc);
    datax  = a;
    update = 1'b1;
    @(posedge clk);
    #1;
    update    = 1'b0;
    datax     = rand256();
    in_flight = 1'b1;
  endtask

  task automatic wait_done();
    int unsigned k = 0;
    while (done_cnt < exp_done && k < MAXC + 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("done_count", 256'(done_cnt), 256'(exp_done));
  endtask

  initial begin
    logic [255:0] a;
    int unsigned  f;
    rst    = 1'b1;
    update = 1'b0;
    datax  = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_err", 256'(err), 256'd0);
    rst = 1'b0;

    // pin the reference model with hand-derived values
    chk("model_inv2", inv_model(256'd2), INV2);
    chk("model_inv_nm1", inv_model(N - 256'd1), N - 256'd1);
    chk("model_inv_np1", inv_model(N + 256'd1), 256'd1);
    chk("model_inv3", mulmod(inv_model(256'd3), 256'd3), 256'd1);

    // directed operands (expected latency 0 = only the MAX_CYCLES bound)
    start_op(256'd1, 3);           wait_done();
    chk("lit_inv1", result, 256'd1);
    start_op(256'd2, 0);           wait_done();
    chk("lit_inv2", result, INV2);
    start_op(N - 256'd1, 0);       wait_done();
    chk("lit_inv_nm1", result, N - 256'd1);
    start_op(N + 256'd1, 3);       wait_done();
    chk("lit_inv_np1", result, 256'd1);
    start_op(256'd0, 2);           wait_done();
    chk("lit_err0", 256'(err), 256'd1);
    start_op(N, 2);                wait_done();
    chk("lit_errN", {255'd0, err} | result, 256'd1);
    start_op('1, 0);               wait_done();
    start_op(256'd3, 0);           wait_done();

    // update while busy must be ignored
    start_op(256'd5, 0);
    repeat (10) @(negedge clk);
    #1;
    datax  = 256'd7;
    update = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("ignored_update_dones", 256'(done_cnt), 256'(exp_done));

    // update in FIN ignored, update the following cycle accepted
    start_op(256'd1, 3);
    wait_done();
    datax  = 256'd2;
    update = 1'b1;
    @(posedge clk);
    #1;
    f = cyc;
    push_exp(256'd2, 0, f);
    @(posedge clk);
    #1;
    update    = 1'b0;
    in_flight = 1'b1;
    wait_done();
    chk("after_fin_inv2", result, INV2);

    // random operands
    for (int i = 0; i < 20; i++) begin
      a = rand256();
      if (i == 0) a = N - 256'd2;
      start_op(a, 0);
      wait_done();
    end

    // reset 100 cycles into an operation aborts without a done pulse
    a = rand256() | {1'b1, 255'd0};
    start_op(a, 0);
    repeat (100) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    void'(q.pop_back());
    exp_done--;
    in_flight = 1'b0;
    chk("abort_result", result, 256'd0);
    chk("abort_done", 256'(done), 256'd0);
    chk("abort_busy", 256'(busy), 256'd0);
    chk("abort_err", 256'(err), 256'd0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 256'(done_cnt), 256'(exp_done));
    start_op(256'd2, 0);
    wait_done();
    chk("post_reset_inv2", result, INV2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
